// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin sharing of one ALU between requesters A and B, one op in flight.
// Define ALU_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES with oError.
module alu_request_arbiter #(
    parameter int WIDTH          = 32,
    parameter int OP_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReqA,
    input  logic                  iReqB,
    input  logic [OP_WIDTH-1:0]   iOpA,
    input  logic [OP_WIDTH-1:0]   iOpB,
    input  logic [6*WIDTH-1:0]    iSrcA,
    input  logic [6*WIDTH-1:0]    iSrcB,
    output logic                  oAckA,
    output logic                  oAckB,
    output logic                  oDoneA,
    output logic                  oDoneB,
    output logic [3*WIDTH-1:0]    oResult,
    output logic                  oBranchTaken,
    output logic                  oBranchNotTaken,
    output logic                  oError,
    output logic                  oBusy,
    output logic [OP_WIDTH-1:0]   oALUOperation,
    output logic [6*WIDTH-1:0]    oALUOperands,
    output logic                  oTriggerALU,
    input  logic [3*WIDTH-1:0]    iALUResult,
    input  logic                  iALUOutputReady,
    input  logic                  iBranchTaken,
    input  logic                  iBranchNotTaken
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_next;
    logic grant_b, last_b, pick_b, err, timeout;

`ifdef ALU_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    always_ff @(posedge Clock) begin
        if (Reset || state != WAIT) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + 16'd1;
    end
    assign timeout = state == WAIT && !iALUOutputReady && wait_cnt == 16'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
    assign timeout = 1'b0;
`endif

    // On a tie the requester that did not win last time goes first.
    assign pick_b = iReqB && (!iReqA || !last_b);

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE  ? ((iReqA || iReqB) ? ISSUE : IDLE)
                   : state == ISSUE ? WAIT
                   : state == WAIT  ? ((iALUOutputReady || timeout) ? DONE : WAIT)
                   : IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            grant_b         <= 1'b0;
            last_b          <= 1'b1;
            err             <= 1'b0;
            oALUOperation   <= '0;
            oALUOperands    <= '0;
            oResult         <= '0;
            oBranchTaken    <= 1'b0;
            oBranchNotTaken <= 1'b0;
        end else if (state == IDLE && (iReqA || iReqB)) begin
            grant_b       <= pick_b;
            last_b        <= pick_b;
            oALUOperation <= pick_b ? iOpB : iOpA;
            oALUOperands  <= pick_b ? iSrcB : iSrcA;
        end else if (state == WAIT && (iALUOutputReady || timeout)) begin
            err             <= timeout;
            oResult         <= iALUOutputReady ? iALUResult : '0;
            oBranchTaken    <= iALUOutputReady && iBranchTaken;
            oBranchNotTaken <= iALUOutputReady && iBranchNotTaken;
        end
    end

    assign oBusy       = state != IDLE;
    assign oTriggerALU = state == ISSUE;
    assign oAckA       = state == ISSUE && !grant_b;
    assign oAckB       = state == ISSUE && grant_b;
    assign oDoneA      = state == DONE && !grant_b;
    assign oDoneB      = state == DONE && grant_b;
    assign oError      = state == DONE && err;
endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb_alu_request_arbiter: randomized bench with an ALU stub, requester agents and a round-robin grant model.
module tb_alu_request_arbiter;
    localparam int W = 32, OW = 16;
    typedef bit bq_t[$];
    typedef struct { bit b; int cyc; logic [OW-1:0] op; logic [6*W-1:0] src; logic [OW-1:0] aop; logic [6*W-1:0] asrc; } ack_t;
    typedef struct { bit b; int cyc; logic [3*W-1:0] res; logic bt; logic bnt; logic err; } done_t;
    typedef struct { int cyc; int d; logic [3*W-1:0] res; logic bt; logic bnt; } trig_t;

    logic Clock = 1'b0, Reset;
    logic iReqA, iReqB, oAckA, oAckB, oDoneA, oDoneB, oBranchTaken, oBranchNotTaken, oError, oBusy, oTriggerALU;
    logic iALUOutputReady, iBranchTaken, iBranchNotTaken;
    logic [OW-1:0] iOpA, iOpB, oALUOperation;
    logic [6*W-1:0] iSrcA, iSrcB, oALUOperands;
    logic [3*W-1:0] oResult, iALUResult;

    ack_t ack_q[$];
    done_t done_q[$];
    trig_t trig_q[$];
    int cyc, req_a, req_b, ackd_a, ackd_b, rise_a, rise_b, alu_cnt, alu_delay, total, passed;
    bit rand_delay, early, use_fixed;
    logic [3*W-1:0] fixed_res, pend_res;
    logic pend_bt, pend_bnt;

    alu_request_arbiter #(.WIDTH(W), .OP_WIDTH(OW), .TIMEOUT_CYCLES(8)) dut (
        .Clock(Clock), .Reset(Reset), .iReqA(iReqA), .iReqB(iReqB), .iOpA(iOpA), .iOpB(iOpB),
        .iSrcA(iSrcA), .iSrcB(iSrcB), .oAckA(oAckA), .oAckB(oAckB), .oDoneA(oDoneA), .oDoneB(oDoneB),
        .oResult(oResult), .oBranchTaken(oBranchTaken), .oBranchNotTaken(oBranchNotTaken), .oError(oError),
        .oBusy(oBusy), .oALUOperation(oALUOperation), .oALUOperands(oALUOperands), .oTriggerALU(oTriggerALU),
        .iALUResult(iALUResult), .iALUOutputReady(iALUOutputReady), .iBranchTaken(iBranchTaken),
        .iBranchNotTaken(iBranchNotTaken)
    );

    always #5 Clock = ~Clock;

    function automatic logic [6*W-1:0] rand_src();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stub ALU: componentwise sum of the two source vectors.
    function automatic logic [3*W-1:0] alu_f(input logic [6*W-1:0] s);
        return {s[6*W-1:5*W] + s[3*W-1:2*W], s[5*W-1:4*W] + s[2*W-1:W], s[4*W-1:3*W] + s[W-1:0]};
    endfunction

    // Grant order when A and B keep requesting until na and nb ops are served.
    function automatic bq_t rr(input int na, input int nb, inout bit last_b);
        bq_t q;
        while (na + nb > 0) begin
            bit pick;
            if (na == 0) pick = 1'b1;
            else if (nb == 0) pick = 1'b0;
            else pick = !last_b;
            q.push_back(pick);
            if (pick) nb--; else na--;
            last_b = pick;
        end
        return q;
    endfunction

    // One clock of bench activity at the falling edge: monitor, requesters and ALU stub.
    task automatic tick();
        int d;
        @(negedge Clock);
        cyc++;
        if (oDoneA || oDoneB) done_q.push_back(done_t'{oDoneB, cyc, oResult, oBranchTaken, oBranchNotTaken, oError});
        if (oAckA) begin
            ack_q.push_back(ack_t'{1'b0, cyc, iOpA, iSrcA, oALUOperation, oALUOperands});
            ackd_a++;
            iOpA = OW'($urandom);
            iSrcA = rand_src();
        end
        if (oAckB) begin
            ack_q.push_back(ack_t'{1'b1, cyc, iOpB, iSrcB, oALUOperation, oALUOperands});
            ackd_b++;
            iOpB = OW'($urandom);
            iSrcB = rand_src();
        end
        iALUOutputReady = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                iALUOutputReady = 1'b1;
                iALUResult = pend_res;
                iBranchTaken = pend_bt;
                iBranchNotTaken = pend_bnt;
            end
        end
        if (oTriggerALU) begin
            d = rand_delay ? int'($urandom_range(1, 4)) : alu_delay;
            pend_res = use_fixed ? fixed_res : alu_f(oALUOperands);
            pend_bt = 1'($urandom);
            pend_bnt = 1'($urandom);
            trig_q.push_back(trig_t'{cyc, d, pend_res, pend_bt, pend_bnt});
            alu_cnt = d;
            if (early) begin
                iALUOutputReady = 1'b1;
                iALUResult = ~pend_res;
                iBranchTaken = ~pend_bt;
            end
        end
        if (!iReqA && req_a > ackd_a) rise_a = cyc;
        if (!iReqB && req_b > ackd_b) rise_b = cyc;
        iReqA = req_a > ackd_a;
        iReqB = req_b > ackd_b;
    endtask

    task automatic run_idle(output bit ok);
        int n = 0;
        do begin tick(); n++; end
        while (!(req_a == ackd_a && req_b == ackd_b && !oBusy && alu_cnt == 0) && n < 300);
        ok = req_a == ackd_a && req_b == ackd_b && !oBusy && alu_cnt == 0;
    endtask

    task automatic clear_logs();
        ack_q.delete(); done_q.delete(); trig_q.delete();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        total++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", oBusy); else passed++;
        total++; if ({oAckA, oAckB, oDoneA, oDoneB, oTriggerALU, oError} !== 6'b0) $display("FAIL reset_pulses: got %b expected 000000", {oAckA, oAckB, oDoneA, oDoneB, oTriggerALU, oError}); else passed++;
        total++; if ({oResult, oBranchTaken, oBranchNotTaken} !== '0) $display("FAIL reset_result: got %h expected 0", oResult); else passed++;
        total++; if ({oALUOperation, oALUOperands} !== '0) $display("FAIL reset_latched: got %h expected 0", {oALUOperation, oALUOperands}); else passed++;
        Reset = 1'b0;
        repeat (2) tick();
        total++; if (oBusy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", oBusy); else passed++;
    endtask

    task automatic test_single();
        bit ok;
        logic [6*W-1:0] src = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        logic [3*W-1:0] res = {32'd7, 32'd9, 32'd11};
        clear_logs();
        alu_delay = 3; use_fixed = 1'b1; fixed_res = res;
        iOpA = 16'h0001; iSrcA = src;
        req_a++;
        run_idle(ok);
        use_fixed = 1'b0;
        total++; if (!ok) $display("FAIL single_complete: got busy=%b expected idle", oBusy); else passed++;
        total++; if (ack_q.size() != 1 || ack_q[0].b) $display("FAIL single_ack: got %0d acks expected 1 to A", ack_q.size()); else passed++;
        total++; if (ack_q[0].cyc != rise_a + 1) $display("FAIL single_ack_latency: got %0d expected %0d", ack_q[0].cyc, rise_a + 1); else passed++;
        total++; if (trig_q.size() != 1 || trig_q[0].cyc != ack_q[0].cyc) $display("FAIL single_trigger: got cycle %0d expected %0d", trig_q[0].cyc, ack_q[0].cyc); else passed++;
        total++; if (ack_q[0].aop !== 16'h0001 || ack_q[0].asrc !== src) $display("FAIL single_latch: got %h expected %h", ack_q[0].asrc, src); else passed++;
        total++; if (done_q.size() != 1 || done_q[0].b) $display("FAIL single_done: got %0d dones expected 1 to A", done_q.size()); else passed++;
        total++; if (done_q[0].cyc != trig_q[0].cyc + 4) $display("FAIL single_done_latency: got %0d expected %0d", done_q[0].cyc, trig_q[0].cyc + 4); else passed++;
        total++; if (done_q[0].res !== res) $display("FAIL single_result: got %h expected %h", done_q[0].res, res); else passed++;
        total++; if (oResult !== res || oALUOperands !== src) $display("FAIL single_hold: got %h expected %h", oResult, res); else passed++;
    endtask

    task automatic test_tie();
        bit ok, last_b;
        bq_t exp;
        do_reset();
        alu_delay = 1; last_b = 1'b1;
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            exp = r == 0 ? rr(2, 1, last_b) : rr(1, 1, last_b);
            req_a += r == 0 ? 2 : 1;
            req_b += 1;
            run_idle(ok);
            total++; if (!ok || ack_q.size() != exp.size()) $display("FAIL tie_count: got %0d expected %0d", ack_q.size(), exp.size()); else passed++;
            for (int i = 0; i < exp.size(); i++) begin
                total++; if (ack_q[i].b !== exp[i] || done_q[i].b !== exp[i]) $display("FAIL tie_order: round %0d slot %0d got %b expected %b", r, i, ack_q[i].b, exp[i]); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        alu_delay = 2;
        req_b += 3;
        run_idle(ok);
        total++; if (!ok || ack_q.size() != 3 || done_q.size() != 3) $display("FAIL b2b_count: got %0d expected 3", done_q.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++; if (ack_q[i].b !== 1'b1 || done_q[i].b !== 1'b1) $display("FAIL b2b_grant: slot %0d got %b expected 1", i, ack_q[i].b); else passed++;
            total++; if (done_q[i].cyc != trig_q[i].cyc + 3) $display("FAIL b2b_latency: got %0d expected %0d", done_q[i].cyc, trig_q[i].cyc + 3); else passed++;
            if (i > 0) begin
                total++; if (ack_q[i].cyc - done_q[i-1].cyc != 2) $display("FAIL b2b_gap: got %0d expected 2", ack_q[i].cyc - done_q[i-1].cyc); else passed++;
            end
        end
    endtask

    task automatic test_ready_in_issue();
        bit ok;
        clear_logs();
        alu_delay = 3; early = 1'b1;
        req_a++;
        run_idle(ok);
        early = 1'b0;
        total++; if (!ok || done_q.size() != 1) $display("FAIL early_dones: got %0d expected 1", done_q.size()); else passed++;
        total++; if (done_q[0].res !== trig_q[0].res || done_q[0].bt !== trig_q[0].bt) $display("FAIL early_result: got %h expected %h", done_q[0].res, trig_q[0].res); else passed++;
        total++; if (done_q[0].cyc != trig_q[0].cyc + 4) $display("FAIL early_latency: got %0d expected %0d", done_q[0].cyc, trig_q[0].cyc + 4); else passed++;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int n = 0;
        clear_logs();
        alu_delay = 10;
        req_a++;
        while (trig_q.size() == 0 && n < 20) begin tick(); n++; end
        total++; if (trig_q.size() == 0) $display("FAIL rstwait_trigger: got none expected 1"); else passed++;
        repeat (2) tick();
        total++; if (oBusy !== 1'b1) $display("FAIL rstwait_busy: got %b expected 1", oBusy); else passed++;
        Reset = 1'b1;
        tick();
        total++; if (oBusy !== 1'b0 || oDoneA !== 1'b0) $display("FAIL rstwait_idle: got busy=%b done=%b expected 0", oBusy, oDoneA); else passed++;
        Reset = 1'b0;
        run_idle(ok);
        total++; if (!ok || done_q.size() != 0 || oResult !== '0) $display("FAIL rstwait_dropped: got %0d dones expected 0", done_q.size()); else passed++;
        clear_logs();
        alu_delay = 2;
        req_a++;
        run_idle(ok);
        total++; if (!ok || done_q.size() != 1 || done_q[0].b) $display("FAIL rstwait_fresh: got %0d dones expected 1 to A", done_q.size()); else passed++;
        total++; if (done_q[0].res !== alu_f(ack_q[0].src)) $display("FAIL rstwait_result: got %h expected %h", done_q[0].res, alu_f(ack_q[0].src)); else passed++;
    endtask

`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_logs();
        alu_delay = 20;
        req_a++;
        run_idle(ok);
        total++; if (!ok || done_q.size() != 1 || done_q[0].b) $display("FAIL timeout_done: got %0d dones expected 1 to A", done_q.size()); else passed++;
        total++; if (done_q[0].err !== 1'b1) $display("FAIL timeout_error: got %b expected 1", done_q[0].err); else passed++;
        total++; if (done_q[0].res !== '0 || done_q[0].bt !== 1'b0 || done_q[0].bnt !== 1'b0) $display("FAIL timeout_result: got %h expected 0", done_q[0].res); else passed++;
        total++; if (done_q[0].cyc != trig_q[0].cyc + 9) $display("FAIL timeout_latency: got %0d expected %0d", done_q[0].cyc, trig_q[0].cyc + 9); else passed++;
        total++; if (oResult !== '0 || oBusy !== 1'b0) $display("FAIL timeout_late_ready: got %h expected 0", oResult); else passed++;
    endtask
`endif

    task automatic test_random();
        bit ok, last_b;
        bq_t exp;
        int na, nb;
        do_reset();
        last_b = 1'b1; rand_delay = 1'b1;
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            na = $urandom_range(0, 3);
            nb = $urandom_range(0, 3);
            if (na + nb == 0) na = 1;
            exp = rr(na, nb, last_b);
            req_a += na; req_b += nb;
            run_idle(ok);
            total++; if (!ok || ack_q.size() != exp.size() || done_q.size() != exp.size()) $display("FAIL rand_count: round %0d got %0d expected %0d", r, done_q.size(), exp.size()); else passed++;
            for (int i = 0; i < exp.size(); i++) begin
                total++; if (ack_q[i].b !== exp[i] || done_q[i].b !== exp[i]) $display("FAIL rand_grant: round %0d slot %0d got %b expected %b", r, i, ack_q[i].b, exp[i]); else passed++;
                total++; if (ack_q[i].aop !== ack_q[i].op || ack_q[i].asrc !== ack_q[i].src) $display("FAIL rand_latch: got %h expected %h", ack_q[i].aop, ack_q[i].op); else passed++;
                total++; if (done_q[i].res !== alu_f(ack_q[i].src) || done_q[i].bt !== trig_q[i].bt || done_q[i].bnt !== trig_q[i].bnt || done_q[i].err !== 1'b0) $display("FAIL rand_result: got %h expected %h", done_q[i].res, alu_f(ack_q[i].src)); else passed++;
                total++; if (done_q[i].cyc != trig_q[i].cyc + trig_q[i].d + 1) $display("FAIL rand_latency: got %0d expected %0d", done_q[i].cyc, trig_q[i].cyc + trig_q[i].d + 1); else passed++;
                if (i > 0) begin
                    total++; if (ack_q[i].cyc - done_q[i-1].cyc != 2) $display("FAIL rand_gap: got %0d expected 2", ack_q[i].cyc - done_q[i-1].cyc); else passed++;
                end
            end
        end
        rand_delay = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        {iReqA, iReqB, iALUOutputReady, iBranchTaken, iBranchNotTaken} = '0;
        iOpA = '0; iOpB = '0; iSrcA = rand_src(); iSrcB = rand_src(); iALUResult = '0;
        {cyc, req_a, req_b, ackd_a, ackd_b, rise_a, rise_b, alu_cnt, total, passed} = '0;
        alu_delay = 1; rand_delay = 1'b0; early = 1'b0; use_fixed = 1'b0;
        fixed_res = '0; pend_res = '0; pend_bt = 1'b0; pend_bnt = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_ready_in_issue();
        test_reset_in_wait();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
